// File: rtl/time_counter_bcd_pkg.sv
// rtl/time_counter_bcd_pkg.sv - shared BCD limits and digit helpers for the time-of-day counter
package time_counter_bcd_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] PM_START = 8'h12;

    // Valid packed BCD orders the same as binary, so q >= max also catches a bad tens digit.
    function automatic logic bcd_wraps(input logic [7:0] q, input logic [7:0] max);
        return (q[BCD_W-1:0] > 4'd9) || (q >= max);
    endfunction

    function automatic logic [7:0] bcd_next(input logic [7:0] q, input logic [7:0] max);
        if (bcd_wraps(q, max)) begin
            return 8'h00;
        end else if (q[BCD_W-1:0] == 4'd9) begin
            return {q[2*BCD_W-1:BCD_W] + 4'd1, 4'd0};
        end else begin
            return {q[2*BCD_W-1:BCD_W], q[BCD_W-1:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/time_counter_bcd_counter.sv
// rtl/time_counter_bcd_counter.sv - two-digit BCD field counter with wrap at MAX and clear
module bcd_counter_mod
    import time_counter_bcd_pkg::*;
#(
    parameter logic [7:0] MAX  = 8'h59,
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clk_1hz,
    input  logic       cr,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] q,
    output logic       carry_out
);

    logic [7:0] r_q;

    always_ff @(posedge clk_1hz or negedge cr) begin
        if (!cr) begin
            r_q <= INIT;
        end else if (clr) begin
            r_q <= 8'h00;
        end else if (inc) begin
            r_q <= bcd_next(r_q, MAX);
        end
    end

    // An out-of-range value carries like MAX; the top decides whether the carry is used.
    assign q         = r_q;
    assign carry_out = inc & bcd_wraps(r_q, MAX);

endmodule

// File: rtl/time_counter_bcd.sv
// rtl/time_counter_bcd.sv - 24-hour BCD hh:mm:ss counter with adjust inputs and day rollover strobe
module time_counter_bcd
    import time_counter_bcd_pkg::*;
#(
    parameter logic [7:0] HOUR_INIT = 8'h00,
    parameter logic [7:0] MIN_INIT  = 8'h00,
    parameter logic [7:0] SEC_INIT  = 8'h00
) (
    input  logic       clk_1hz,
    input  logic       cr,
    input  logic       en,
    input  logic       adj_hour,
    input  logic       adj_min,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       pm,
    output logic       day_pulse
);

    logic w_adjust;
    logic w_sec_inc;
    logic w_min_inc;
    logic w_hour_inc;
    logic w_sec_carry;
    logic w_min_carry;
    logic w_hour_carry;
    logic r_day_pulse;

    // Adjust beats counting; in adjust mode no field ripples into the next.
    assign w_adjust   = adj_hour | adj_min;
    assign w_sec_inc  = ~w_adjust & en;
    assign w_min_inc  = w_adjust ? adj_min  : w_sec_carry;
    assign w_hour_inc = w_adjust ? adj_hour : w_min_carry;

    bcd_counter_mod #(.MAX(SEC_MAX), .INIT(SEC_INIT)) u_sec (
        .clk_1hz   (clk_1hz),
        .cr        (cr),
        .inc       (w_sec_inc),
        .clr       (w_adjust),
        .q         (second),
        .carry_out (w_sec_carry)
    );

    bcd_counter_mod #(.MAX(MIN_MAX), .INIT(MIN_INIT)) u_min (
        .clk_1hz   (clk_1hz),
        .cr        (cr),
        .inc       (w_min_inc),
        .clr       (1'b0),
        .q         (minute),
        .carry_out (w_min_carry)
    );

    bcd_counter_mod #(.MAX(HOUR_MAX), .INIT(HOUR_INIT)) u_hour (
        .clk_1hz   (clk_1hz),
        .cr        (cr),
        .inc       (w_hour_inc),
        .clr       (1'b0),
        .q         (hour),
        .carry_out (w_hour_carry)
    );

    always_ff @(posedge clk_1hz or negedge cr) begin
        if (!cr) begin
            r_day_pulse <= 1'b0;
        end else begin
            r_day_pulse <= ~w_adjust & w_hour_carry;
        end
    end

    assign day_pulse = r_day_pulse;
    assign pm        = (hour >= PM_START);

endmodule

// File: tb/tb_time_counter_bcd.sv
// tb/tb_time_counter_bcd.sv - directed scoreboard bench for the 24-hour BCD time counter
module tb_time_counter_bcd;

    logic       clk_1hz = 1'b0;
    logic       cr      = 1'b0;
    logic       en      = 1'b0;
    logic       adj_hour = 1'b0;
    logic       adj_min  = 1'b0;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic       pm;
    logic       day_pulse;

    int n_cmp = 0;
    int n_err = 0;
    int n_step = 0;

    int mh = 0;
    int mm = 0;
    int ms = 0;
    int mdp = 0;

    logic [25:0] sb[$];

    time_counter_bcd #(.HOUR_INIT(8'h00), .MIN_INIT(8'h00), .SEC_INIT(8'h00)) dut (
        .clk_1hz   (clk_1hz),
        .cr        (cr),
        .en        (en),
        .adj_hour  (adj_hour),
        .adj_min   (adj_min),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .pm        (pm),
        .day_pulse (day_pulse)
    );

    always #5 clk_1hz = ~clk_1hz;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [25:0] exp_vec();
        return {to_bcd(mh), to_bcd(mm), to_bcd(ms), logic'(mh >= 12), logic'(mdp != 0)};
    endfunction

    function automatic logic [25:0] obs_vec();
        return {hour, minute, second, pm, day_pulse};
    endfunction

    task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed hh:mm:ss/pm/dp=%h required %h", tag, obs, expv);
        end
    endtask

    task automatic model_update(input logic e, input logic ah, input logic am);
        mdp = 0;
        if (ah || am) begin
            ms = 0;
            if (am) mm = (mm + 1) % 60;
            if (ah) mh = (mh + 1) % 24;
        end else if (e) begin
            ms++;
            if (ms == 60) begin
                ms = 0;
                mm++;
                if (mm == 60) begin
                    mm = 0;
                    mh++;
                    if (mh == 24) begin
                        mh = 0;
                        mdp = 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic e, input logic ah, input logic am);
        @(negedge clk_1hz);
        en = e;
        adj_hour = ah;
        adj_min = am;
        model_update(e, ah, am);
        sb.push_back(exp_vec());
        @(posedge clk_1hz);
        #1;
        n_step++;
        check($sformatf("step%0d", n_step), obs_vec(), sb.pop_front());
    endtask

    task automatic goto_time(input int h, input int m, input int s);
        while (mh != h) step(1'b0, 1'b1, 1'b0);
        do step(1'b0, 1'b0, 1'b1); while (mm != m);
        while (ms != s) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk_1hz);
        en = 1'b1;
        #2;
        cr = 1'b0;
        #1;
        mh = 0; mm = 0; ms = 0; mdp = 0;
        check("async_reset", obs_vec(), exp_vec());
        @(posedge clk_1hz);
        #1;
        check("reset_held_over_edge", obs_vec(), exp_vec());
        @(negedge clk_1hz);
        en = 1'b0;
        cr = 1'b1;
    endtask

    initial begin
        #2;
        check("power_on_reset", obs_vec(), exp_vec());
        @(negedge clk_1hz);
        cr = 1'b1;

        goto_time(12, 34, 56);
        pulse_reset();

        goto_time(0, 0, 58);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        goto_time(9, 59, 59);
        step(1'b1, 1'b0, 1'b0);

        goto_time(23, 59, 59);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        goto_time(0, 59, 30);
        step(1'b1, 1'b0, 1'b1);
        goto_time(23, 10, 5);
        step(1'b1, 1'b1, 1'b0);

        goto_time(11, 58, 20);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);

        goto_time(5, 6, 7);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: observed %0d left required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
